// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - programmable down-counting timer with one-shot and periodic modes
module timer_dev #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    state_t             state, state_n;
    logic               ctrl_en, ctrl_en_n;
    logic [1:0]         ctrl_mode, ctrl_mode_n;
    logic               ctrl_im, ctrl_im_n;
    logic [CNT_W-1:0]   preset, preset_n;
    logic [CNT_W-1:0]   count, count_n;
    logic               int_flag, int_flag_n;
    logic               en_hw;
    logic               wr_ctrl, wr_preset;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);

    // Next-state logic: FSM step first, then CPU register writes take priority over it
    always_comb begin
        state_n     = state;
        count_n     = count;
        en_hw       = ctrl_en;
        ctrl_mode_n = ctrl_mode;
        ctrl_im_n   = ctrl_im;
        preset_n    = preset;
        int_flag_n  = int_flag;

        case (state)
            S_IDLE: begin
                if (ctrl_en) state_n = S_LOAD;
            end
            S_LOAD: begin
                count_n = preset;
                state_n = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_en) begin
                    state_n = S_IDLE;
                end else if (count <= CNT_W'(1)) begin
                    // A preset of 0 behaves like 1: one tick, then expire
                    count_n = '0;
                    state_n = S_INT;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            S_INT: begin
                if (ctrl_mode == MODE_PERIODIC) begin
                    state_n = S_LOAD;
                end else begin
                    en_hw   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        ctrl_en_n = en_hw;
        if (wr_ctrl) begin
            ctrl_en_n   = din[0];
            ctrl_mode_n = din[2:1];
            ctrl_im_n   = din[3];
        end
        if (wr_preset) preset_n = din[CNT_W-1:0];

        // Periodic mode gives a one-cycle pulse; otherwise the flag is sticky until a CPU write
        if (ctrl_mode == MODE_PERIODIC) begin
            int_flag_n = (state_n == S_INT);
        end else if (wr_ctrl || wr_preset) begin
            int_flag_n = 1'b0;
        end else if (state_n == S_INT) begin
            int_flag_n = 1'b1;
        end
    end

    // State and register update; irq is registered from the same next-state values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            int_flag  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_n;
            ctrl_en   <= ctrl_en_n;
            ctrl_mode <= ctrl_mode_n;
            ctrl_im   <= ctrl_im_n;
            preset    <= preset_n;
            count     <= count_n;
            int_flag  <= int_flag_n;
            irq       <= ctrl_im_n & int_flag_n;
        end
    end

    // Read mux; narrow registers zero-extend
    always_comb begin
        dout = '0;
        case (addr)
            2'd0:    dout[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    dout[CNT_W-1:0] = preset;
            2'd2:    dout[CNT_W-1:0] = count;
            default: dout = '0;
        endcase
    end

endmodule
